// File: rtl/spi_slave_mode.sv
// SPI slave link (any mode, DATA_W-bit words): pins pass SYNC_STAGES flops, events act SYNC_STAGES+1 clk after the pin.
// No backpressure on the SPI side: a stalled rx consumer gets rx_data overwritten (rx_overrun); no tx word sends TX_IDLE (tx_underrun).
module spi_slave_mode #(
  parameter int                DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b1,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic [7:0]        word_cnt,
  output logic              frame_err,
  output logic              rx_overrun,
  output logic              tx_underrun
);
  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W);
  localparam logic [1:0]        ST_IDLE  = 2'd0;
  localparam logic [1:0]        ST_LOAD  = 2'd1;
  localparam logic [1:0]        ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ss_d;
  logic [SYNC_STAGES:0]   r_flush;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [7:0]             r_word_cnt;
  logic [DATA_W-1:0]      r_tx_shift, r_rx_shift, r_rx_data;
  logic                   r_rx_valid, r_frame_err, r_rx_overrun, r_tx_underrun;

  logic                   w_sclk, w_ss, w_mosi, w_lead, w_trail, w_sample, w_shift;
  logic                   w_ss_fall, w_ss_rise, w_word_done;
  logic [CNT_W-1:0]       w_bit_inc;
  logic [DATA_W-1:0]      w_rx_next, w_tx_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= CPOL;
      r_ss_d      <= 1'b1;
      r_flush     <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead   = (w_sclk != CPOL) && (r_sclk_d == CPOL);
  assign w_trail  = (w_sclk == CPOL) && (r_sclk_d != CPOL);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead : w_trail;
  // Until the chain holds real pin history, a low SS left over from reset must not look like a start.
  assign w_ss_fall = !w_ss && r_ss_d && r_flush[SYNC_STAGES];
  assign w_ss_rise = w_ss && !r_ss_d;

  assign w_bit_inc   = r_bit_cnt + CNT_W'(1);
  assign w_word_done = w_sample && (w_bit_inc == LAST_BIT);
  assign w_rx_next   = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], w_mosi} : {w_mosi, r_rx_shift[DATA_W-1:1]};
  assign w_tx_next   = MSB_FIRST ? {r_tx_shift[DATA_W-2:0], 1'b0} : {1'b0, r_tx_shift[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_frame_err   <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state    <= ST_LOAD;
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        ST_LOAD: begin
          r_tx_shift    <= tx_valid ? tx_data : TX_IDLE;
          r_tx_underrun <= !tx_valid;
          r_bit_cnt     <= '0;
          r_state       <= w_ss_rise ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_frame_err <= (r_bit_cnt != '0);
            r_state     <= ST_IDLE;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= w_bit_inc;
            end
            // The first bit of a word is already on MISO straight out of LOAD.
            if (w_shift && (r_bit_cnt != '0)) r_tx_shift <= w_tx_next;
            if (w_word_done) begin
              r_rx_data    <= w_rx_next;
              r_rx_valid   <= 1'b1;
              r_rx_overrun <= r_rx_valid && !rx_ready;
              if (r_word_cnt != 8'hFF) r_word_cnt <= r_word_cnt + 8'd1;
              r_state      <= ST_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MISO        = !SS && (MSB_FIRST ? r_tx_shift[DATA_W-1] : r_tx_shift[0]);
  assign tx_ready    = (r_state == ST_LOAD);
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = !w_ss;
  assign word_cnt    = r_word_cnt;
  assign frame_err   = r_frame_err;
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench for spi_slave_mode: four 8-bit MSB-first instances (modes 0..3) share one SPI master,
// plus a 16-bit LSB-first mode-1 instance with its own select; MISO is captured at each master sample point.
module tb_spi_slave_mode;
  localparam int Q = 40;

  logic clk;
  logic rst, ss8, ss16, ph, mosi, rdy, tx_en, clr;
  logic [31:0] tx_tbl [5][4];
  logic [31:0] cap [5];
  logic [31:0] miso_w0 [4];
  logic [31:0] miso_w1 [4];
  int n_chk = 0;
  int n_fail = 0;

  wire [31:0] p_log0 [5];
  wire [31:0] p_log1 [5];
  wire [31:0] p_rxd [5];
  wire [31:0] p_nrx [5];
  wire [31:0] p_nfe [5];
  wire [31:0] p_nov [5];
  wire [31:0] p_nun [5];
  wire [7:0]  p_wc [5];
  wire        p_rxv [5];
  wire        p_busy [5];
  wire        p_miso [5];
  wire        p_txr [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar m = 0; m < 5; m++) begin : g_dut
    localparam int W      = (m == 4) ? 16 : 8;
    localparam bit P_CPOL = (m == 2) || (m == 3);
    localparam bit P_CPHA = (m == 1) || (m == 3) || (m == 4);
    logic [W-1:0] txd, rxd;
    logic         txr, rxv, bsy, fe, ov, un, miso, ss_pin;
    logic [7:0]   wc;
    int           tx_idx = 0;
    int           n_rx = 0, n_fe = 0, n_ov = 0, n_un = 0;
    logic [31:0]  log0 = '0, log1 = '0;

    assign ss_pin = (m == 4) ? ss16 : ss8;
    assign txd    = W'(tx_tbl[m][tx_idx[1:0]]);

    spi_slave_mode #(
      .DATA_W(W), .CPOL(P_CPOL), .CPHA(P_CPHA), .MSB_FIRST(m != 4),
      .SYNC_STAGES((m == 4) ? 3 : 2)
    ) u_dut (
      .clk(clk), .rst(rst), .SCLK(ph ^ P_CPOL), .SS(ss_pin), .MOSI(mosi), .MISO(miso),
      .tx_data(txd), .tx_valid(tx_en), .tx_ready(txr),
      .rx_data(rxd), .rx_valid(rxv), .rx_ready(rdy),
      .busy(bsy), .word_cnt(wc), .frame_err(fe), .rx_overrun(ov), .tx_underrun(un)
    );

    always @(posedge clk) begin
      if (clr) tx_idx <= 0;
      else if (txr && tx_en) tx_idx <= tx_idx + 1;
    end

    always @(negedge clk) begin
      if (clr) begin
        n_rx <= 0; n_fe <= 0; n_ov <= 0; n_un <= 0; log0 <= '0; log1 <= '0;
      end else begin
        if (rxv && rdy) begin
          if (n_rx == 0) log0 <= 32'(rxd);
          if (n_rx == 1) log1 <= 32'(rxd);
          n_rx <= n_rx + 1;
        end
        if (fe) n_fe <= n_fe + 1;
        if (ov) n_ov <= n_ov + 1;
        if (un) n_un <= n_un + 1;
      end
    end

    assign p_log0[m] = log0;
    assign p_log1[m] = log1;
    assign p_rxd[m]  = 32'(rxd);
    assign p_nrx[m]  = n_rx;
    assign p_nfe[m]  = n_fe;
    assign p_nov[m]  = n_ov;
    assign p_nun[m]  = n_un;
    assign p_wc[m]   = wc;
    assign p_rxv[m]  = rxv;
    assign p_busy[m] = bsy;
    assign p_miso[m] = miso;
    assign p_txr[m]  = txr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cpha_of(input int m);
    return (m == 1) || (m == 3) || (m == 4);
  endfunction

  function automatic logic [31:0] take(input logic [31:0] c, input logic b, input int i, input bit msb);
    return msb ? {c[30:0], b} : (c | (32'(b) << i));
  endfunction

  task automatic clear();
    clr = 1'b1;
    #20;
    clr = 1'b0;
  endtask

  // Master: MOSI set a quarter period before the leading phase, held a quarter period past the trailing one.
  task automatic send_word(input logic [31:0] w, input int n, input bit msb);
    for (int m = 0; m < 5; m++) cap[m] = '0;
    for (int i = 0; i < n; i++) begin
      mosi = msb ? w[n-1-i] : w[i];
      #(Q);
      for (int m = 0; m < 5; m++) if (!cpha_of(m)) cap[m] = take(cap[m], p_miso[m], i, msb);
      ph = 1'b1;
      #(2*Q);
      for (int m = 0; m < 5; m++) if (cpha_of(m)) cap[m] = take(cap[m], p_miso[m], i, msb);
      ph = 1'b0;
      #(Q);
    end
  endtask

  initial begin
    rst = 1'b0; ss8 = 1'b1; ss16 = 1'b1; ph = 1'b0; mosi = 1'b0;
    rdy = 1'b1; tx_en = 1'b1; clr = 1'b0;
    for (int m = 0; m < 5; m++) for (int k = 0; k < 4; k++) tx_tbl[m][k] = '0;
    clear();
    chk("rst_txr", 32'(p_txr[1]), 0);
    chk("rst_rxv", 32'(p_rxv[1]), 0);
    chk("rst_busy", 32'(p_busy[1]), 0);
    chk("rst_wc", 32'(p_wc[1]), 0);
    chk("rst_rxd", p_rxd[1], 0);
    chk("rst_miso", 32'(p_miso[1]), 0);
    rst = 1'b1;
    #100;

    // Mode 1 single word
    for (int m = 0; m < 4; m++) tx_tbl[m][0] = 32'hA5;
    clear(); ss8 = 1'b0; #100;
    send_word(32'h3C, 8, 1'b1); #100;
    chk("t1_miso", cap[1], 32'hA5);
    chk("t1_rx", p_log0[1], 32'h3C);
    chk("t1_nrx", p_nrx[1], 1);
    chk("t1_wc", 32'(p_wc[1]), 1);
    chk("t1_busy", 32'(p_busy[1]), 1);
    chk("t1_rxv_clr", 32'(p_rxv[1]), 0);
    ss8 = 1'b1; #100;
    chk("t1_idle", 32'(p_busy[1]), 0);

    // Two words per frame in every mode
    for (int m = 0; m < 4; m++) begin
      tx_tbl[m][0] = 32'h11; tx_tbl[m][1] = 32'h22; tx_tbl[m][2] = 32'h33;
    end
    clear(); ss8 = 1'b0; #100;
    send_word(32'h81, 8, 1'b1);
    for (int m = 0; m < 4; m++) miso_w0[m] = cap[m];
    send_word(32'h7E, 8, 1'b1);
    for (int m = 0; m < 4; m++) miso_w1[m] = cap[m];
    #100;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t2_rx0_m%0d", m), p_log0[m], 32'h81);
      chk($sformatf("t2_rx1_m%0d", m), p_log1[m], 32'h7E);
      chk($sformatf("t2_wc_m%0d", m), 32'(p_wc[m]), 2);
      chk($sformatf("t2_miso0_m%0d", m), miso_w0[m], 32'h11);
      chk($sformatf("t2_miso1_m%0d", m), miso_w1[m], 32'h22);
      chk($sformatf("t2_nun_m%0d", m), p_nun[m], 0);
    end
    ss8 = 1'b1; #100;

    // 16-bit LSB first
    tx_tbl[4][0] = 32'hBEEF;
    clear(); ss16 = 1'b0; #100;
    send_word(32'h1234, 16, 1'b0); #100;
    chk("t3_rx", p_log0[4], 32'h1234);
    chk("t3_miso", cap[4], 32'hBEEF);
    chk("t3_wc", 32'(p_wc[4]), 1);
    ss16 = 1'b1; #100;
    chk("t3_nfe", p_nfe[4], 0);

    // Consumer stalled across three words
    clear(); rdy = 1'b0; ss8 = 1'b0; #100;
    send_word(32'hC3, 8, 1'b1);
    send_word(32'h5A, 8, 1'b1);
    send_word(32'h96, 8, 1'b1); #100;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t4_nov_m%0d", m), p_nov[m], 2);
      chk($sformatf("t4_rxd_m%0d", m), p_rxd[m], 32'h96);
      chk($sformatf("t4_rxv_m%0d", m), 32'(p_rxv[m]), 1);
    end
    rdy = 1'b1; #50;
    for (int m = 0; m < 4; m++) chk($sformatf("t4_rxv_clr_m%0d", m), 32'(p_rxv[m]), 0);
    ss8 = 1'b1; #100;

    // No tx word, frame aborted after five bits
    tx_en = 1'b0;
    clear(); ss8 = 1'b0; #100;
    send_word(32'h16, 5, 1'b1);
    ss8 = 1'b1; #100;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t5_nun_m%0d", m), p_nun[m], 1);
      chk($sformatf("t5_nfe_m%0d", m), p_nfe[m], 1);
      chk($sformatf("t5_nrx_m%0d", m), p_nrx[m], 0);
      chk($sformatf("t5_busy_m%0d", m), 32'(p_busy[m]), 0);
      chk($sformatf("t5_miso_m%0d", m), cap[m], 32'h1F);
    end
    tx_en = 1'b1;

    // Reset mid-word with SS held low, then a fresh frame
    clear(); ss8 = 1'b0; #100;
    send_word(32'hA0, 3, 1'b1);
    rst = 1'b0; #20; rst = 1'b1; #100;
    send_word(32'hFF, 8, 1'b1); #100;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t6_nrx_m%0d", m), p_nrx[m], 0);
      chk($sformatf("t6_rxv_m%0d", m), 32'(p_rxv[m]), 0);
      chk($sformatf("t6_wc_m%0d", m), 32'(p_wc[m]), 0);
    end
    ss8 = 1'b1; #100;
    ss8 = 1'b0; #100;
    send_word(32'h69, 8, 1'b1); #100;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t6_rx_m%0d", m), p_log0[m], 32'h69);
      chk($sformatf("t6_wc1_m%0d", m), 32'(p_wc[m]), 1);
    end
    ss8 = 1'b1; #100;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_mode.md
Name: spi_slave_mode

Overview:
- Parametrised SPI slave link block; successor to the fixed CPOL=0/CPHA=1, 8-bit slave comm block.
- Sits between the PC-side SPI pins and the sniffer command/data logic.
- Supports any SPI mode, configurable word width and bit order, and synchronised pin inputs.
- Exposes valid/ready word streams plus frame, error, overrun and underrun status.

Parameters:
- DATA_W, 8: bits per SPI word (2..32).
- CPOL, 0: idle SCLK level.
- CPHA, 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.
- SYNC_STAGES, 2: flip-flop stages on SCLK/SS/MOSI (2..3).
- TX_IDLE, 8'hFF (zero-extended to DATA_W): word sent when no tx word is available.

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- rst  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock (asynchronous).
- SS  in  1  slave select, active low (asynchronous).
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block will take tx_data this cycle.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  frame in progress (synchronised SS low).
- word_cnt  out  8  words completed in the current frame; saturates at 255.
- frame_err  out  1  1-cycle pulse: SS rose mid-word.
- rx_overrun  out  1  1-cycle pulse: word completed while rx_valid was still 1.
- tx_underrun  out  1  1-cycle pulse: TX_IDLE loaded because tx_valid was 0.

Behaviour:
- Reset: all flops clear asynchronously when rst=0. Outputs are then 0: MISO, tx_ready, rx_data, rx_valid, busy, word_cnt and all pulses. State is IDLE. Synchroniser flops reset to CPOL/1/0 (SCLK/SS/MOSI).
- Input path:
  - SCLK, SS and MOSI each pass through SYNC_STAGES flops.
  - Edge detect compares the synchronised value with one extra delayed flop.
  - Pin-to-event latency is SYNC_STAGES+1 clk cycles.
- Edge roles:
  - lead = synchronised SCLK leaving CPOL; trail = returning to CPOL.
  - CPHA=0: sample = lead, shift = trail.
  - CPHA=1: sample = trail, shift = lead.
- State machine IDLE/LOAD/SHIFT:
  - IDLE: busy=0. On synchronised SS falling -> LOAD; clear word_cnt and bit_cnt.
  - LOAD (1 cycle):
    - tx_ready=1. If tx_valid=1, load tx_data into tx_shift; else load TX_IDLE and pulse tx_underrun.
    - Clear bit_cnt. -> SHIFT.
  - SHIFT:
    - On a sample edge: shift the synchronised MOSI into rx_shift (per MSB_FIRST); bit_cnt+1.
    - On a shift edge: advance tx_shift, but only when bit_cnt != 0 (CPHA=1 skips advance on the first lead, because the first bit is already presented).
    - When a sample edge makes bit_cnt==DATA_W:
      - rx_data <= assembled word; rx_valid <= 1; word_cnt+1 (saturating).
      - If rx_valid was already 1 and rx_ready=0: pulse rx_overrun; rx_data is still overwritten.
      - -> LOAD. The next word's first bit must appear before the next shift edge, which the clk >= 8x SCLK requirement guarantees.
    - Synchronised SS rising:
      - bit_cnt != 0: pulse frame_err, discard the partial word.
      - In all cases -> IDLE.
- MISO: the current output bit of tx_shift (MSB or LSB per MSB_FIRST) while SS pin is low; 0 otherwise.
- rx handshake: rx_valid clears the cycle after rx_valid && rx_ready. A simultaneous completion and accept leaves rx_valid=1 with the new word and no overrun.
- Simultaneous edge and SS rise in the same cycle: SS rise wins; the edge is ignored.
- busy = inverse of synchronised SS.
- SS falling while in LOAD/SHIFT cannot occur (SS already low). Glitches shorter than the synchroniser depth are not required to be filtered.
- Mid-frame reset: returns to IDLE. The next frame starts only on a fresh SS falling edge; a held-low SS is not a start.

Test Plan:
- Mode 1, DATA_W=8, MSB first. tx word 0xA5 queued; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; word_cnt=1.
- Modes 0, 2, 3 each. Master sends 0x81 then 0x7E in one frame -> rx words 0x81, 0x7E; word_cnt=2; MISO matches tx words 0x11, 0x22.
- MSB_FIRST=0, DATA_W=16. Master sends 0x1234 LSB first -> rx_data=0x1234.
- rx_ready held 0 while 3 words are sent -> rx_overrun pulses twice; rx_data = third word.
- tx_valid=0 at frame start -> MISO carries 0xFF; tx_underrun pulses once. SS raised after 5 bits -> frame_err pulse, no rx_valid, busy=0.
- rst asserted mid-word, released, 8 further SCLK pulses with SS still low -> no rx_valid; next SS low-high-low frame receives normally.
